fetch_rf_wr_ctrl: RTL and testbench

Write-side controller for the 96-pixel-wide single-port fetch buffer. It accepts 16-pixel (128-bit) beats from the fetch DMA over a valid/ready handshake and packs six beats into one 96-pixel row. It then issues one write per row on the buffer's wrif_* port, starting at a programmable row address and wrapping modulo 96. Reads from the motion-estimation side have priority: a pending row write stalls while rd_busy_i is high, because the buffer has one port.

---
 rtl/fetch_rf_wr_ctrl_pkg.sv | 22 ++
 rtl/fetch_rf_wr_ctrl.sv | 83 ++++++++
 tb/tb_fetch_rf_wr_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_rf_wr_ctrl_pkg.sv
// fetch_rf_wr_ctrl_pkg: fetch buffer geometry, FSM encoding and row address wrap helper.
package fetch_rf_wr_ctrl_pkg;
    localparam int PIXEL_WIDTH   = 8;
    localparam int ROW_PIX       = 96;
    localparam int BEAT_PIX      = 16;
    localparam int ADDR_W        = 7;
    localparam int ROW_DEPTH     = 96;
    localparam int BEATS_PER_ROW = ROW_PIX / BEAT_PIX;
    localparam int BEAT_W        = BEAT_PIX * PIXEL_WIDTH;
    localparam int ROW_W         = ROW_PIX * PIXEL_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(ROW_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction
endpackage

// File: rtl/fetch_rf_wr_ctrl.sv
// fetch_rf_wr_ctrl: packs six 16-pixel beats per row and writes rows into the single-port fetch buffer.
module fetch_rf_wr_ctrl
    import fetch_rf_wr_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [ADDR_W-1:0]   row_num_i,
    input  logic                beat_valid_i,
    input  logic [BEAT_W-1:0]   beat_data_i,
    output logic                beat_ready_o,
    input  logic                rd_busy_i,
    output logic                wrif_en_o,
    output logic [ADDR_W-1:0]   wrif_addr_o,
    output logic [ROW_W-1:0]    wrif_data_o,
    output logic                busy_o,
    output logic                done_o
);
    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_beat_cnt;
    logic [ADDR_W-1:0]   r_rows_left;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ROW_W-1:0]    r_row;
    logic                w_beat_acc;
    logic                w_last_beat;
    logic                w_wr_done;

    assign w_beat_acc  = (r_state == FILL) && beat_valid_i;
    assign w_last_beat = (r_beat_cnt == 3'(BEATS_PER_ROW - 1));
    // The reader owns the port whenever rd_busy_i is high, so a row write only lands in a free cycle.
    assign w_wr_done   = (r_state == WRITE) && !rd_busy_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = (row_num_i == '0) ? DONE : FILL;
            FILL:    if (w_beat_acc && w_last_beat) w_next = WRITE;
            WRITE:   if (w_wr_done) w_next = (r_rows_left == ADDR_W'(1)) ? DONE : FILL;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_rows_left <= '0;
            r_wr_addr   <= '0;
            r_row       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start_i) begin
                r_wr_addr   <= base_addr_i;
                r_rows_left <= row_num_i;
                r_beat_cnt  <= '0;
            end
            if (w_beat_acc) begin
                r_row[int'(r_beat_cnt) * BEAT_W +: BEAT_W] <= beat_data_i;
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 3'd1;
            end
            if (w_wr_done) begin
                r_rows_left <= r_rows_left - ADDR_W'(1);
                r_wr_addr   <= next_addr(r_wr_addr);
            end
        end
    end

    assign beat_ready_o = (r_state == FILL);
    assign wrif_en_o    = w_wr_done;
    assign wrif_addr_o  = r_wr_addr;
    assign wrif_data_o  = r_row;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rstn && start_i) begin
            assert (base_addr_i < ADDR_W'(ROW_DEPTH));
            assert (row_num_i <= ADDR_W'(ROW_DEPTH));
        end
    end
endmodule

// File: tb/tb_fetch_rf_wr_ctrl.sv
// tb_fetch_rf_wr_ctrl: randomized bench; expected row writes are queued by a reference model and checked by a monitor.
module tb_fetch_rf_wr_ctrl;
    import fetch_rf_wr_ctrl_pkg::*;

    logic              clk = 0;
    logic              rstn = 0;
    logic              start_i = 0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic [ADDR_W-1:0] row_num_i = '0;
    logic              beat_valid_i = 0;
    logic [BEAT_W-1:0] beat_data_i = '0;
    logic              beat_ready_o;
    logic              rd_busy_i = 0;
    logic              wrif_en_o;
    logic [ADDR_W-1:0] wrif_addr_o;
    logic [ROW_W-1:0]  wrif_data_o;
    logic              busy_o;
    logic              done_o;

    fetch_rf_wr_ctrl dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .base_addr_i(base_addr_i),
        .row_num_i(row_num_i), .beat_valid_i(beat_valid_i), .beat_data_i(beat_data_i),
        .beat_ready_o(beat_ready_o), .rd_busy_i(rd_busy_i), .wrif_en_o(wrif_en_o),
        .wrif_addr_o(wrif_addr_o), .wrif_data_o(wrif_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               addr;
        logic [ROW_W-1:0] data;
    } wr_t;

    wr_t              exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               done_seen = 0;
    int               exp_done = 0;
    int               gap_pct = 0;
    int               busy_pct = 0;
    int               m_base, m_row, m_beat;
    logic [ROW_W-1:0] m_acc;
    logic [ROW_W-1:0] last_row;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && wrif_en_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", ROW_W'(wrif_addr_o), ROW_W'(e.addr));
                check("wr_data", wrif_data_o, e.data);
            end
        end
        if (rstn && done_o) done_seen++;
    end

    task automatic drive_busy();
        if (busy_pct >= 0) rd_busy_i = ($urandom_range(99) < busy_pct);
    endtask

    task automatic model_beat(input logic [BEAT_W-1:0] d);
        wr_t e;
        m_acc[m_beat*BEAT_W +: BEAT_W] = d;
        m_beat++;
        if (m_beat == BEATS_PER_ROW) begin
            e.addr = (m_base + m_row) % ROW_DEPTH;
            e.data = m_acc;
            last_row = m_acc;
            exp_q.push_back(e);
            m_row++;
            m_beat = 0;
        end
    endtask

    task automatic start_load(input int base, input int rows);
        start_i = 1;
        base_addr_i = ADDR_W'(base);
        row_num_i = ADDR_W'(rows);
        @(posedge clk); #1;
        start_i = 0;
        m_base = base;
        m_row = 0;
        m_beat = 0;
        exp_done++;
    endtask

    task automatic present_beat(input logic [BEAT_W-1:0] d);
        int t = 0;
        while ($urandom_range(99) < gap_pct) begin
            beat_valid_i = 0;
            beat_data_i = {4{$urandom}};
            drive_busy();
            @(posedge clk); #1;
        end
        beat_valid_i = 1;
        beat_data_i = d;
        model_beat(d);
        while (!beat_ready_o && t < 200) begin
            drive_busy();
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("beat_timeout", 1'b1, 1'b0);
        drive_busy();
        @(posedge clk); #1;
        beat_valid_i = 0;
    endtask

    function automatic logic [BEAT_W-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 300) begin
            drive_busy();
            @(posedge clk); #1;
            t++;
        end
        rd_busy_i = 0;
        check("idle_busy", ROW_W'(busy_o), '0);
        check("done_count", ROW_W'(done_seen), ROW_W'(exp_done));
        check("queue_empty", ROW_W'(exp_q.size()), '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, ROW_W'(busy_o), '0);
        check({tag, "_done"}, ROW_W'(done_o), '0);
        check({tag, "_wren"}, ROW_W'(wrif_en_o), '0);
        check({tag, "_ready"}, ROW_W'(beat_ready_o), '0);
        check({tag, "_addr"}, ROW_W'(wrif_addr_o), '0);
        check({tag, "_data"}, wrif_data_o, '0);
    endtask

    logic [BEAT_W-1:0] beats[12];

    initial begin
        logic [BEAT_W-1:0] d;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1;
        @(posedge clk); #1;

        // Single row with pixel i = i
        start_load(0, 1);
        for (int k = 0; k < BEATS_PER_ROW; k++) begin
            for (int j = 0; j < BEAT_PIX; j++) d[j*PIXEL_WIDTH +: PIXEL_WIDTH] = 8'(k*BEAT_PIX + j);
            present_beat(d);
        end
        check("t1_wren_next", ROW_W'(wrif_en_o), ROW_W'(1));
        @(posedge clk); #1;
        check("t1_done", ROW_W'(done_o), ROW_W'(1));
        @(posedge clk); #1;
        check("t1_done_low", ROW_W'(done_o), '0);
        wait_idle();

        // Wrap around the buffer end with random read contention
        busy_pct = 30;
        start_load(94, 4);
        for (int i = 0; i < 4*BEATS_PER_ROW; i++) present_beat(rand_beat());
        wait_idle();

        // Read contention held for three cycles at WRITE entry
        busy_pct = 0;
        start_load(50, 1);
        for (int i = 0; i < BEATS_PER_ROW-1; i++) present_beat(rand_beat());
        busy_pct = -1;
        rd_busy_i = 1;
        present_beat(rand_beat());
        for (int i = 0; i < 3; i++) begin
            check("t3_wren_low", ROW_W'(wrif_en_o), '0);
            check("t3_ready_low", ROW_W'(beat_ready_o), '0);
            check("t3_addr_hold", ROW_W'(wrif_addr_o), ROW_W'(50));
            check("t3_data_hold", wrif_data_o, last_row);
            @(posedge clk); #1;
        end
        rd_busy_i = 0;
        #1;
        check("t3_wren_high", ROW_W'(wrif_en_o), ROW_W'(1));
        check("t3_ready_wr", ROW_W'(beat_ready_o), '0);
        busy_pct = 0;
        wait_idle();

        // Same two rows, gap-free then bursty
        for (int i = 0; i < 12; i++) beats[i] = rand_beat();
        start_load(20, 2);
        for (int i = 0; i < 12; i++) present_beat(beats[i]);
        wait_idle();
        gap_pct = 50;
        busy_pct = 20;
        start_load(20, 2);
        for (int i = 0; i < 12; i++) present_beat(beats[i]);
        wait_idle();
        gap_pct = 0;
        busy_pct = 0;

        // Zero rows, plus a start while busy that must be ignored
        start_load(5, 0);
        check("t5_done", ROW_W'(done_o), ROW_W'(1));
        start_i = 1;
        row_num_i = ADDR_W'(5);
        @(posedge clk); #1;
        start_i = 0;
        check("t5_idle", ROW_W'(busy_o), '0);
        check("t5_done_once", ROW_W'(done_o), '0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_still_idle", ROW_W'(busy_o), '0);
        wait_idle();

        // Reset in the middle of a fill discards the partial row
        start_load(10, 2);
        for (int i = 0; i < 3; i++) present_beat(rand_beat());
        rstn = 0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rstn = 1;
        m_beat = 0;
        exp_done--;
        @(posedge clk); #1;
        start_load(33, 1);
        for (int i = 0; i < BEATS_PER_ROW; i++) present_beat(rand_beat());
        wait_idle();

        // Random loads
        gap_pct = 30;
        busy_pct = 30;
        for (int n = 0; n < 6; n++) begin
            start_load($urandom_range(95), $urandom_range(1, 5));
            for (int i = 0; i < (m_base >= 0 ? row_num_i : 0) * BEATS_PER_ROW; i++) present_beat(rand_beat());
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
